memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter SEG_LO_BASE, default 12'hE00, base of the lower display segment.
REQ-002 SHALL have parameter SEG_HI_BASE, default 12'hE80, base of the upper display segment.
REQ-003 SHALL have parameter SEG_LEN, default 80, nibbles per segment.
REQ-004 SHALL provide ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  reset; asynchronous, active-low.
- cpu_access  in  1  CPU drives a memory access this cycle.
- cpu_write_en  in  1  CPU access is a write.
- cpu_addr  in  12  CPU nibble address.
- cpu_write_data  in  4  CPU write data.
- cpu_read_data  out  4  CPU read data.
- host_req  in  1  host request; held until host_ack.
- host_write_en  in  1  host access is a write.
- host_addr  in  12  host address.
- host_write_data  in  4  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_read_data  out  4  host read data; valid with host_ack.
- frame_start  in  1  pulse; start a display scan.
- scan_busy  out  1  scan in progress.
- lcd_wr_en  out  1  one scanned nibble is valid.
- lcd_index  out  8  scanned nibble index, 0-159.
- lcd_data  out  4  scanned nibble.
- mem_addr  out  12  shared memory address.
- mem_write_en  out  1  shared memory write strobe.
- mem_write_data  out  4  shared memory write data.
- mem_read_data  in  4  shared memory read data; valid one cycle after the address.

Function
REQ-005 SHALL grant exactly one requester per cycle, fixed priority: CPU > host > scanner.
REQ-006 SHALL never stall the CPU; when cpu_access=1, mem_* SHALL carry the CPU fields combinationally in that same cycle.
REQ-007 SHALL drive mem_addr=0, mem_write_en=0 and mem_write_data=0 when no requester is granted.
REQ-008 SHALL register a 2-bit owner tag (NONE/CPU/HOST/SCAN) for each granted cycle and route the next cycle's mem_read_data by that tag.
REQ-009 SHALL hold cpu_read_data at the last CPU read value; it SHALL update exactly one cycle after a granted CPU read and SHALL NOT change on CPU writes.
REQ-010 SHALL grant the host only when host_req=1, cpu_access=0 and no host access is outstanding.
REQ-011 SHALL pulse host_ack for one cycle exactly one cycle after the host grant, for both reads and writes.
REQ-012 SHALL update host_read_data only with a read host_ack; it SHALL hold its value otherwise.
REQ-013 SHALL NOT grant the host in its own ack cycle; maximum host rate is one access per 2 cycles.
REQ-014 Scanner FSM states: IDLE, SCAN.
- IDLE -> SCAN on frame_start; the scan counter is cleared to 0.
- SCAN -> IDLE when the read for index 159 is granted.
REQ-015 Scan address mapping:
- index i < SEG_LEN reads SEG_LO_BASE+i.
- index i >= SEG_LEN reads SEG_HI_BASE+(i-SEG_LEN).
- The scanner only ever reads; it never writes.
REQ-016 SHALL advance the scan counter only on a scanner grant; a scanner denied by CPU or host SHALL retry the same index.
REQ-017 SHALL pulse lcd_wr_en one cycle after each scanner grant, with lcd_index equal to the granted index and lcd_data=mem_read_data.
REQ-018 scan_busy SHALL be 1 in SCAN and remain 1 through the final lcd_wr_en pulse.
REQ-019 frame_start while scan_busy=1 SHALL set a pending flag. At most one start SHALL be pending; further starts are dropped. The pending scan SHALL begin the cycle after the current scan's final lcd_wr_en.
REQ-020 Simultaneous cpu_access, host_req and scanner demand: CPU granted; host and scanner wait with their state unchanged.
REQ-021 The host port SHALL be able to address the full 12-bit space; no address decoding is done in this block.

Reset
REQ-022 On reset_n=0, asynchronously:
- outputs cleared: cpu_read_data=0, host_ack=0, host_read_data=0, scan_busy=0, lcd_wr_en=0, lcd_index=0, lcd_data=0.
- internal state cleared: owner tag=NONE, FSM=IDLE, pending flag=0, host-outstanding flag=0.
REQ-023 Reset asserted mid-scan or mid-host-access SHALL abandon the operation; no host_ack or lcd_wr_en SHALL be issued for it after release.

Verification
REQ-024 CPU reads 0x005 holding 4'hA, with host_req=1 at the same time -> mem_addr=0x005 that cycle, cpu_read_data=4'hA next cycle, host_ack delayed until the first cycle with cpu_access=0.
REQ-025 Host writes 4'h3 to 0x100, then reads 0x100 with cpu_access=0 -> host_ack pulses on cycles 2 and 4, host_read_data=4'h3, no back-to-back grants.
REQ-026 frame_start with idle CPU and host -> 160 lcd_wr_en pulses on consecutive cycles; index 79 comes from 0xE4F, index 80 from 0xE80; scan_busy low after index 159.
REQ-027 Scan with cpu_access high on alternate cycles -> no index skipped or duplicated; total 160 pulses in about 320 cycles.
REQ-028 frame_start asserted twice during a scan -> exactly one additional scan follows.
REQ-029 reset_n dropped at index 50 -> all outputs 0 immediately; no lcd_wr_en after release until the next frame_start.

Source files
------------

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - shared nibble memory arbiter: CPU > host > display scanner
`timescale 1ns/1ps
module memory_arbiter #(
    parameter logic [11:0] SEG_LO_BASE = 12'hE00,
    parameter logic [11:0] SEG_HI_BASE = 12'hE80,
    parameter int          SEG_LEN     = 80
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_access,
    input  logic        cpu_write_en,
    input  logic [11:0] cpu_addr,
    input  logic [3:0]  cpu_write_data,
    output logic [3:0]  cpu_read_data,
    input  logic        host_req,
    input  logic        host_write_en,
    input  logic [11:0] host_addr,
    input  logic [3:0]  host_write_data,
    output logic        host_ack,
    output logic [3:0]  host_read_data,
    input  logic        frame_start,
    output logic        scan_busy,
    output logic        lcd_wr_en,
    output logic [7:0]  lcd_index,
    output logic [3:0]  lcd_data,
    output logic [11:0] mem_addr,
    output logic        mem_write_en,
    output logic [3:0]  mem_write_data,
    input  logic [3:0]  mem_read_data
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_HOST = 2'd2;
    localparam logic [1:0] OWN_SCAN = 2'd3;
    localparam logic [7:0] SEG_LEN_W = 8'(SEG_LEN);
    localparam logic [7:0] LAST_IDX  = 8'(2 * SEG_LEN - 1);

    typedef enum logic {S_IDLE, S_SCAN} scan_state_t;

    scan_state_t state_q, state_d;
    logic [1:0]  owner_q;
    logic        owner_wr_q;
    logic        host_pend_q;
    logic        pending_q;
    logic [7:0]  scan_idx_q;
    logic [7:0]  lcd_index_q;
    logic [3:0]  cpu_rd_q;
    logic [3:0]  host_rd_q;
    logic [3:0]  lcd_data_q;
    logic        host_grant;
    logic        scan_grant;
    logic        scan_start;
    logic [11:0] scan_addr;

    assign host_grant = !cpu_access && host_req && !host_pend_q;
    assign scan_grant = !cpu_access && !host_grant && (state_q == S_SCAN);
    assign scan_addr  = (scan_idx_q < SEG_LEN_W)
                      ? SEG_LO_BASE + {4'd0, scan_idx_q}
                      : SEG_HI_BASE + {4'd0, scan_idx_q - SEG_LEN_W};

    always_comb begin
        mem_addr       = 12'd0;
        mem_write_en   = 1'b0;
        mem_write_data = 4'd0;
        if (cpu_access) begin
            mem_addr       = cpu_addr;
            mem_write_en   = cpu_write_en;
            mem_write_data = cpu_write_data;
        end else if (host_grant) begin
            mem_addr       = host_addr;
            mem_write_en   = host_write_en;
            mem_write_data = host_write_data;
        end else if (scan_grant) begin
            mem_addr       = scan_addr;
        end
    end

    // Owner tag and access direction travel one cycle to meet mem_read_data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q     <= OWN_NONE;
            owner_wr_q  <= 1'b0;
            host_pend_q <= 1'b0;
        end else begin
            host_pend_q <= host_grant;
            if (cpu_access) begin
                owner_q    <= OWN_CPU;
                owner_wr_q <= cpu_write_en;
            end else if (host_grant) begin
                owner_q    <= OWN_HOST;
                owner_wr_q <= host_write_en;
            end else if (scan_grant) begin
                owner_q    <= OWN_SCAN;
                owner_wr_q <= 1'b0;
            end else begin
                owner_q    <= OWN_NONE;
                owner_wr_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rd_q    <= 4'd0;
            host_rd_q   <= 4'd0;
            lcd_data_q  <= 4'd0;
            lcd_index_q <= 8'd0;
        end else begin
            if (owner_q == OWN_CPU && !owner_wr_q)
                cpu_rd_q <= mem_read_data;
            if (owner_q == OWN_HOST && !owner_wr_q)
                host_rd_q <= mem_read_data;
            if (owner_q == OWN_SCAN)
                lcd_data_q <= mem_read_data;
            if (scan_grant)
                lcd_index_q <= scan_idx_q;
        end
    end

    // Returned data is visible in the completion cycle, then held.
    assign cpu_read_data  = (owner_q == OWN_CPU && !owner_wr_q) ? mem_read_data : cpu_rd_q;
    assign host_read_data = (owner_q == OWN_HOST && !owner_wr_q) ? mem_read_data : host_rd_q;
    assign lcd_data       = (owner_q == OWN_SCAN) ? mem_read_data : lcd_data_q;
    assign host_ack       = (owner_q == OWN_HOST);
    assign lcd_wr_en      = (owner_q == OWN_SCAN);
    assign lcd_index      = lcd_index_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (frame_start || pending_q) state_d = S_SCAN;
            S_SCAN: if (scan_grant && scan_idx_q == LAST_IDX) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Busy covers the trailing lcd_wr_en of the last index.
    always_comb begin
        scan_start = (state_q == S_IDLE) && (frame_start || pending_q);
        scan_busy  = (state_q == S_SCAN) || (owner_q == OWN_SCAN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_idx_q <= 8'd0;
            pending_q  <= 1'b0;
        end else begin
            if (scan_start)
                scan_idx_q <= 8'd0;
            else if (scan_grant)
                scan_idx_q <= scan_idx_q + 8'd1;
            if (scan_start)
                pending_q <= 1'b0;
            else if (frame_start && scan_busy)
                pending_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter
`timescale 1ns/1ps
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_access, cpu_write_en;
    logic [11:0] cpu_addr;
    logic [3:0]  cpu_write_data, cpu_read_data;
    logic        host_req, host_write_en, host_ack;
    logic [11:0] host_addr;
    logic [3:0]  host_write_data, host_read_data;
    logic        frame_start, scan_busy, lcd_wr_en;
    logic [7:0]  lcd_index;
    logic [3:0]  lcd_data;
    logic [11:0] mem_addr;
    logic        mem_write_en;
    logic [3:0]  mem_write_data;
    logic [3:0]  mem_read_data = 4'd0;

    memory_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_access(cpu_access), .cpu_write_en(cpu_write_en), .cpu_addr(cpu_addr),
        .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
        .host_req(host_req), .host_write_en(host_write_en), .host_addr(host_addr),
        .host_write_data(host_write_data), .host_ack(host_ack), .host_read_data(host_read_data),
        .frame_start(frame_start), .scan_busy(scan_busy), .lcd_wr_en(lcd_wr_en),
        .lcd_index(lcd_index), .lcd_data(lcd_data),
        .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cnt = 0;
    logic [3:0] seed4 = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] init_val(input logic [11:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ seed4;
    endfunction

    // Synchronous memory attached to the shared port: data one cycle after address.
    bit [3:0] sim_mem [4096];
    bit       sim_written [4096];
    always @(posedge clk) begin
        mem_read_data <= sim_written[mem_addr] ? sim_mem[mem_addr] : init_val(mem_addr);
        if (mem_write_en) begin
            sim_mem[mem_addr]     <= mem_write_data;
            sim_written[mem_addr] <= 1'b1;
        end
    end

    int lcd_idx_q[$];
    int lcd_dat_q[$];
    int lcd_cyc_q[$];
    always @(negedge clk) begin
        if (reset_n && lcd_wr_en) begin
            lcd_idx_q.push_back(int'(lcd_index));
            lcd_dat_q.push_back(int'(lcd_data));
            lcd_cyc_q.push_back(cyc);
        end
        if (reset_n && host_ack) ack_cnt <= ack_cnt + 1;
    end

    logic [3:0] ref_mem [4096];

    function automatic int seg_addr(input int i);
        return (i < 80) ? (32'hE00 + i) : (32'hE80 + i - 80);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cpu_access = 0; cpu_write_en = 0; cpu_addr = 0; cpu_write_data = 0;
        host_req = 0; host_write_en = 0; host_addr = 0; host_write_data = 0;
        frame_start = 0;
    endtask

    task automatic check_scans(input string tag, input int nscan);
        chk({tag, "_count"}, lcd_idx_q.size(), 160 * nscan);
        for (int k = 0; k < lcd_idx_q.size() && k < 160 * nscan; k++) begin
            chk({tag, "_index"}, lcd_idx_q[k], k % 160);
            chk({tag, "_data"}, lcd_dat_q[k], int'(ref_mem[seg_addr(k % 160)]));
        end
    endtask

    // Waits for scan_busy to fall; toggles CPU reads when alt is set.
    task automatic run_scan(input bit alt, input int extra_start_a, input int extra_start_b,
                            output int exit_cyc, output int ncyc);
        int n;
        n = 0;
        drv(); idle_inputs(); frame_start = 1;
        smp();
        while (1) begin
            drv();
            frame_start = (n == extra_start_a || n == extra_start_b);
            cpu_access  = alt ? ((n % 2) == 0) : 1'b0;
            cpu_addr    = 12'($urandom_range(0, 12'hDFF));
            n++;
            smp();
            if (!scan_busy) break;
            if (n > 1500) begin
                chk("scan_timeout", 1, 0);
                break;
            end
        end
        idle_inputs();
        exit_cyc = cyc;
        ncyc = n;
    endtask

    int host_st, exit_c, ncyc, acks_before, pulses_before;
    logic [3:0]  h_exp, cpu_hold, host_hold, prev_cpu_exp;
    logic [31:0] exp_addr, exp_we;
    bit          prev_cpu_rd, host_gnt;

    initial begin
        seed4 = 4'($urandom);
        for (int a = 0; a < 4096; a++) ref_mem[a] = init_val(12'(a));
        idle_inputs();
        reset_n = 0;
        #3;
        chk("rst_cpu_read_data", cpu_read_data, 0);
        chk("rst_host_ack", host_ack, 0);
        chk("rst_host_read_data", host_read_data, 0);
        chk("rst_scan_busy", scan_busy, 0);
        chk("rst_lcd_wr_en", lcd_wr_en, 0);
        chk("rst_lcd_index", lcd_index, 0);
        chk("rst_lcd_data", lcd_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        drv(); drv();
        reset_n = 1;

        // CPU writes 4'hA to 0x005; read data must not move on a write
        drv(); cpu_access = 1; cpu_write_en = 1; cpu_addr = 12'h005; cpu_write_data = 4'hA;
        ref_mem[12'h005] = 4'hA;
        smp(); chk("cpu_wr_mem_we", mem_write_en, 1);
        drv(); idle_inputs();
        smp(); chk("cpu_wr_no_rd_update", cpu_read_data, 0);

        // CPU read collides with host request
        drv(); cpu_access = 1; cpu_addr = 12'h005;
        host_req = 1; host_write_en = 0; host_addr = 12'h7AB;
        smp(); chk("c24_mem_addr", mem_addr, 12'h005);
        drv(); cpu_addr = 12'h006;
        smp(); chk("c24_cpu_rd", cpu_read_data, 4'hA);
        chk("c24_no_ack1", host_ack, 0);
        chk("c24_mem_addr2", mem_addr, 12'h006);
        drv(); cpu_access = 0;
        smp(); chk("c24_host_addr", mem_addr, 12'h7AB);
        chk("c24_no_ack2", host_ack, 0);
        drv();
        smp(); chk("c24_ack", host_ack, 1);
        chk("c24_host_rd", host_read_data, ref_mem[12'h7AB]);
        chk("c24_ackcycle_nogrant", mem_addr, 0);
        drv(); idle_inputs();
        smp(); chk("c24_ack_pulse", host_ack, 0);
        cpu_hold = ref_mem[12'h006];
        chk("c24_cpu_hold", cpu_read_data, cpu_hold);

        // Host write then read of 0x100
        drv(); host_req = 1; host_write_en = 1; host_addr = 12'h100; host_write_data = 4'h3;
        smp(); chk("c25_c1_addr", mem_addr, 12'h100);
        chk("c25_c1_we", mem_write_en, 1);
        chk("c25_c1_ack", host_ack, 0);
        drv();
        smp(); chk("c25_c2_ack", host_ack, 1);
        chk("c25_c2_nogrant", mem_addr, 0);
        drv(); host_write_en = 0;
        ref_mem[12'h100] = 4'h3;
        smp(); chk("c25_c3_ack", host_ack, 0);
        chk("c25_c3_addr", mem_addr, 12'h100);
        chk("c25_c3_we", mem_write_en, 0);
        drv();
        smp(); chk("c25_c4_ack", host_ack, 1);
        chk("c25_c4_data", host_read_data, 4'h3);
        drv(); idle_inputs();
        smp(); chk("c25_c5_ack", host_ack, 0);
        host_hold = 4'h3;

        // Random CPU/host traffic against the reference memory
        host_st = 0; prev_cpu_rd = 0; prev_cpu_exp = 0;
        for (int n = 0; n < 400; n++) begin
            drv();
            if (host_st == 3) begin host_st = 0; host_req = 0; end
            else if (host_st == 2) host_st = 3;
            if (host_st == 0 && $urandom_range(0, 2) == 0) begin
                host_req = 1; host_write_en = 1'($urandom);
                host_addr = 12'($urandom); host_write_data = 4'($urandom);
                host_st = 1;
            end
            cpu_access = 1'($urandom); cpu_write_en = 1'($urandom);
            cpu_addr = 12'($urandom); cpu_write_data = 4'($urandom);
            host_gnt = (host_st == 1) && !cpu_access;
            smp();
            exp_addr = cpu_access ? 32'(cpu_addr) : host_gnt ? 32'(host_addr) : 0;
            exp_we   = cpu_access ? 32'(cpu_write_en) : host_gnt ? 32'(host_write_en) : 0;
            chk("rnd_mem_addr", mem_addr, exp_addr);
            chk("rnd_mem_we", mem_write_en, exp_we);
            chk("rnd_host_ack", host_ack, (host_st == 3));
            if (host_st == 3 && !host_write_en) host_hold = h_exp;
            chk("rnd_host_rd", host_read_data, host_hold);
            if (prev_cpu_rd) cpu_hold = prev_cpu_exp;
            chk("rnd_cpu_rd", cpu_read_data, cpu_hold);
            prev_cpu_rd = cpu_access && !cpu_write_en;
            if (cpu_access) begin
                if (cpu_write_en) ref_mem[cpu_addr] = cpu_write_data;
                else prev_cpu_exp = ref_mem[cpu_addr];
            end
            if (host_gnt) begin
                host_st = 2;
                if (host_write_en) ref_mem[host_addr] = host_write_data;
                else h_exp = ref_mem[host_addr];
            end
        end
        drv(); idle_inputs();
        drv();
        chk("rnd_no_lcd", lcd_idx_q.size(), 0);

        // Undisturbed scan: 160 consecutive pulses
        lcd_idx_q.delete(); lcd_dat_q.delete(); lcd_cyc_q.delete();
        run_scan(0, -1, -1, exit_c, ncyc);
        check_scans("idle_scan", 1);
        if (lcd_cyc_q.size() == 160) begin
            chk("idle_consecutive", lcd_cyc_q[159] - lcd_cyc_q[0], 159);
            chk("idle_busy_drop", exit_c - lcd_cyc_q[159], 1);
        end
        chk("idle_i79_data", lcd_dat_q.size() > 79 ? lcd_dat_q[79] : -1, int'(ref_mem[12'hE4F]));
        chk("idle_i80_data", lcd_dat_q.size() > 80 ? lcd_dat_q[80] : -1, int'(ref_mem[12'hE80]));

        // Scan with the CPU stealing every other cycle
        lcd_idx_q.delete(); lcd_dat_q.delete(); lcd_cyc_q.delete();
        run_scan(1, -1, -1, exit_c, ncyc);
        check_scans("alt_scan", 1);
        chk("alt_duration", (ncyc >= 310 && ncyc <= 330), 1);

        // Two extra frame_starts during a scan give exactly one more scan
        lcd_idx_q.delete(); lcd_dat_q.delete(); lcd_cyc_q.delete();
        run_scan(0, 10, 20, exit_c, ncyc);
        check_scans("dbl_scan", 2);
        for (int k = 0; k < 30; k++) drv();
        chk("dbl_no_third", lcd_idx_q.size(), 320);

        // Reset at index 50 with a host access in flight
        lcd_idx_q.delete(); lcd_dat_q.delete(); lcd_cyc_q.delete();
        drv(); frame_start = 1;
        for (int n = 0; n < 400; n++) begin
            smp();
            if (lcd_wr_en && lcd_index == 8'd50) break;
            drv(); frame_start = 0;
            if (lcd_idx_q.size() > 0 && lcd_idx_q[$] == 49) begin
                host_req = 1; host_write_en = 1; host_addr = 12'h321; host_write_data = 4'h5;
            end
        end
        chk("rst50_reached", (lcd_wr_en && lcd_index == 8'd50), 1);
        reset_n = 0;
        #1;
        idle_inputs();
        chk("rst50_cpu_rd", cpu_read_data, 0);
        chk("rst50_host_ack", host_ack, 0);
        chk("rst50_host_rd", host_read_data, 0);
        chk("rst50_busy", scan_busy, 0);
        chk("rst50_lcd_wr_en", lcd_wr_en, 0);
        chk("rst50_lcd_index", lcd_index, 0);
        chk("rst50_lcd_data", lcd_data, 0);
        drv(); drv();
        reset_n = 1;
        acks_before = ack_cnt;
        pulses_before = lcd_idx_q.size();
        for (int k = 0; k < 200; k++) drv();
        smp();
        chk("rst50_no_lcd", lcd_idx_q.size() - pulses_before, 0);
        chk("rst50_no_ack", ack_cnt - acks_before, 0);
        chk("rst50_busy_after", scan_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
